// File: rtl/input_conditioner_if.sv
// Bundle of raw switch/button inputs and conditioned outputs for the
// input conditioner. The master side (board/test harness) drives the raw
// asynchronous inputs; the slave side (the conditioner) drives the clean
// levels, the pause pulse and the downstream reset. There is no
// valid/ready handshake: every signal is a level or a one-cycle pulse
// sampled on the system clock.
interface input_conditioner_if;
    logic adj_raw;
    logic sel_raw;
    logic pause_raw;
    logic rst_raw;
    logic adj;
    logic sel;
    logic pause_tog;
    logic rst_out;

    modport master (
        output adj_raw, sel_raw, pause_raw, rst_raw,
        input  adj, sel, pause_tog, rst_out
    );

    modport slave (
        input  adj_raw, sel_raw, pause_raw, rst_raw,
        output adj, sel, pause_tog, rst_out
    );
endinterface

// File: rtl/input_conditioner.sv
// Input conditioner: synchronizes and debounces four raw front-panel inputs,
// turns the pause button into a one-cycle press pulse, and stretches the
// power-on reset (merged with the debounced reset button) into rst_out.
module input_conditioner #(
    parameter int DB_CYCLES  = 16,
    parameter int POR_CYCLES = 8
) (
    input logic                clk,
    input logic                rst_n,
    input_conditioner_if.slave bus
);

    localparam int NCH    = 4;
    localparam int CH_ADJ = 0;
    localparam int CH_SEL = 1;
    localparam int CH_PSE = 2;
    localparam int CH_RST = 3;
    localparam int CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PW     = $clog2(POR_CYCLES + 1);

    logic [NCH-1:0] raw;
    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] db;
    logic [NCH-1:0] db_nxt;
    logic [CW-1:0]  cnt     [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic           pause_db_q;
    logic [PW-1:0]  por_cnt;
    logic [PW-1:0]  por_cnt_nxt;
    logic           rst_out_q;

    assign raw = {bus.rst_raw, bus.pause_raw, bus.sel_raw, bus.adj_raw};

    // Two-flop synchronizer per raw input; nothing else touches raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce next state: a candidate level must differ from db on
    // DB_CYCLES consecutive samples; any agreeing sample restarts the count.
    always_comb begin
        db_nxt = db;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CW'(DB_CYCLES - 1)) begin
                    db_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = CW'(cnt[i] + 1'b1);
                end
            end
        end
    end

    // Saturating power-on counter next state.
    always_comb begin
        por_cnt_nxt = por_cnt;
        if (por_cnt < PW'(POR_CYCLES)) begin
            por_cnt_nxt = PW'(por_cnt + 1'b1);
        end
    end

    // Debounce state registers for all channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db <= db_nxt;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // POR stretcher, pause edge history and the registered reset output.
    // rst_out is built from next-state values so the flop tracks
    // (por_cnt < POR_CYCLES) | rst_db with no extra cycle of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_db_q <= 1'b0;
            por_cnt    <= '0;
            rst_out_q  <= 1'b1;
        end else begin
            pause_db_q <= db[CH_PSE];
            por_cnt    <= por_cnt_nxt;
            rst_out_q  <= (por_cnt_nxt < PW'(POR_CYCLES)) | db_nxt[CH_RST];
        end
    end

    assign bus.adj       = db[CH_ADJ];
    assign bus.sel       = db[CH_SEL];
    // Rising edge of debounced pause; presses landing in reset are dropped.
    assign bus.pause_tog = db[CH_PSE] & ~pause_db_q & ~rst_out_q;
    assign bus.rst_out   = rst_out_q;

endmodule
